// File: rtl/divider_result_bcd.sv
// ============================================================================
//  Module      : divider_result_bcd
//  Description : Captures divider quotient/remainder and converts both to
//                packed BCD with a shared shift-add-3 engine, one bit per cycle.
//                Define LEADING_ZERO_BLANK_EN to blank leading zero digits (4'hF).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module divider_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  St,
  input  logic [WIDTH-1:0]      Quotient,
  input  logic [WIDTH-1:0]      Remainder,
  input  logic                  Overflow,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [4*DIGITS-1:0]   Q_BCD,
  output logic [4*DIGITS-1:0]   R_BCD
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV_Q = 2'd1;
  localparam logic [1:0] S_CONV_R = 2'd2;

  logic [1:0]          state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    bin;
  logic [WIDTH-1:0]    rem_lat;
  logic [4*DIGITS-1:0] bcd, bcd_adj, bcd_step, q_hold;
  logic                ovf_pend;
  logic                accept, accept_ovf, load_r, finish;

  function automatic logic [4*DIGITS-1:0] fmt(input logic [4*DIGITS-1:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    fmt = v;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'h0) fmt[4*i +: 4] = 4'hF;
      else                             lead = 1'b0;
    end
`endif
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (St && !Overflow) state_next = S_CONV_Q;
      S_CONV_Q: if (cnt == LAST_CNT) state_next = S_CONV_R;
      S_CONV_R: if (cnt == LAST_CNT) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == S_IDLE) && St && !Overflow;
    accept_ovf = (state == S_IDLE) && St && Overflow;
    load_r     = (state == S_CONV_Q) && (cnt == LAST_CNT);
    finish     = (state == S_CONV_R) && (cnt == LAST_CNT);
  end

  // One double-dabble step: correct digits >= 5, then shift bin MSB in
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      rem_lat  <= '0;
      q_hold   <= '0;
      ovf_pend <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      Q_BCD    <= '0;
      R_BCD    <= '0;
    end else begin
      Done     <= 1'b0;
      ovf_pend <= accept_ovf;
      if (ovf_pend) begin
        Done  <= 1'b1;
        Err   <= 1'b1;
        Q_BCD <= {DIGITS{4'hE}};
        R_BCD <= {DIGITS{4'hE}};
      end
      if (accept) begin
        bin     <= Quotient;
        rem_lat <= Remainder;
        bcd     <= '0;
        cnt     <= '0;
        Busy    <= 1'b1;
      end else if (state != S_IDLE) begin
        bcd <= bcd_step;
        bin <= bin << 1;
        cnt <= cnt + 1'b1;
        if (load_r) begin
          q_hold <= bcd_step;
          bin    <= rem_lat;
          bcd    <= '0;
          cnt    <= '0;
        end
        if (finish) begin
          Q_BCD <= fmt(q_hold);
          R_BCD <= fmt(bcd_step);
          Err   <= 1'b0;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_result_bcd.sv
// Randomized bench for divider_result_bcd against an arithmetic decimal model.
`default_nettype none

module tb_divider_result_bcd;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                Clk = 1'b0;
  logic                Rst = 1'b1;
  logic                St = 1'b0;
  logic [WIDTH-1:0]    Quotient = '0;
  logic [WIDTH-1:0]    Remainder = '0;
  logic                Overflow = 1'b0;
  logic                Busy, Done, Err;
  logic [4*DIGITS-1:0] Q_BCD, R_BCD;

  int checks = 0;
  int errors = 0;

  divider_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk(Clk), .Rst(Rst), .St(St),
    .Quotient(Quotient), .Remainder(Remainder), .Overflow(Overflow),
    .Busy(Busy), .Done(Done), .Err(Err), .Q_BCD(Q_BCD), .R_BCD(R_BCD)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Decimal digits by division, optional blanking of leading zeros
  function automatic logic [31:0] model_bcd(input int v);
    int  d [DIGITS];
    logic [31:0] r;
    bit  lead;
    r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = v % 10;
      v    = v / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && d[i] == 0) d[i] = 15;
      else                   lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) r = r | (32'(d[i]) << (4 * i));
    return r;
  endfunction

  // Ticks n edges; Done must appear only on the last one, Busy as given meanwhile
  task automatic expect_done(input string tag, input int n, input bit busy_mid,
                             input logic [31:0] q_exp, input logic [31:0] r_exp,
                             input bit err_exp);
    bit early_done = 1'b0;
    bit busy_bad   = 1'b0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e < n) begin
        if (Done) early_done = 1'b1;
        if (Busy !== busy_mid) busy_bad = 1'b1;
      end
    end
    check({tag, "_no_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check({tag, "_err"}, 32'(Err), 32'(err_exp));
    check({tag, "_q"}, 32'(Q_BCD), q_exp);
    check({tag, "_r"}, 32'(R_BCD), r_exp);
    tick();
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  task automatic run_normal(input string tag, input int q, input int r);
    Quotient = WIDTH'(q); Remainder = WIDTH'(r); Overflow = 1'b0; St = 1'b1;
    tick();
    St = 1'b0;
    Quotient = WIDTH'($urandom); Remainder = WIDTH'($urandom); Overflow = 1'($urandom);
    expect_done(tag, 2 * WIDTH, 1'b1, model_bcd(q), model_bcd(r), 1'b0);
  endtask

  task automatic run_overflow(input string tag);
    Quotient = WIDTH'($urandom); Remainder = WIDTH'($urandom); Overflow = 1'b1; St = 1'b1;
    tick();
    St = 1'b0; Overflow = 1'b0;
    check({tag, "_busy_edge0"}, 32'(Busy), 32'd0);
    expect_done(tag, 1, 1'b0, 32'hEEEEE, 32'hEEEEE, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int q, r, q2, r2;
    bit seen;
    tick(); tick();
    Rst = 1'b0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_q", 32'(Q_BCD), 32'd0);
    check("rst_r", 32'(R_BCD), 32'd0);

    run_normal("t1", 12345, 6789);
    run_normal("t2", 65535, 0);
    run_normal("t6", 42, 7);
    run_overflow("t3");
    run_normal("t3_clear", 1, 9);

    // Reset in the middle of a conversion
    Quotient = 16'd999; Remainder = 16'd888; St = 1'b1;
    tick();
    St = 1'b0;
    for (int e = 1; e < 10; e++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_q", 32'(Q_BCD), 32'd0);
    check("t4_r", 32'(R_BCD), 32'd0);
    seen = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (Done) seen = 1'b1;
    end
    check("t4_no_done", 32'(seen), 32'd0);
    run_normal("t4_after", 314, 159);

    // Re-pulsed St ignored; St held through Done cycle starts a second run
    q = 4321; r = 87; q2 = 50000; r2 = 10;
    Quotient = WIDTH'(q); Remainder = WIDTH'(r); Overflow = 1'b0; St = 1'b1;
    tick();
    St = 1'b0;
    seen = 1'b0;
    for (int e = 1; e < 32; e++) begin
      if (e == 5 || e == 20) begin
        St = 1'b1; Quotient = WIDTH'($urandom); Remainder = WIDTH'($urandom);
      end
      tick();
      St = 1'b0;
      if (Done) seen = 1'b1;
    end
    check("t5_no_early_done", 32'(seen), 32'd0);
    Quotient = WIDTH'(q2); Remainder = WIDTH'(r2); St = 1'b1;
    tick();
    check("t5_done", 32'(Done), 32'd1);
    check("t5_q", 32'(Q_BCD), model_bcd(q));
    check("t5_r", 32'(R_BCD), model_bcd(r));
    tick();
    St = 1'b0;
    check("t5_done_pulse", 32'(Done), 32'd0);
    expect_done("t5_second", 2 * WIDTH, 1'b1, model_bcd(q2), model_bcd(r2), 1'b0);

    // Randomized mix with boundary values
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0:       run_overflow("rnd_ovf");
        1:       run_normal("rnd_edge", ($urandom_range(0, 1) != 0) ? 65535 : 0,
                            ($urandom_range(0, 1) != 0) ? 0 : 65535);
        default: run_normal("rnd", int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
